// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, funct/ALUOp encodings and issue-stage state encoding
package alu_ctrl_pkg;

    localparam logic [3:0] CODE_MUL   = 4'b0000;
    localparam logic [3:0] CODE_SUB   = 4'b0001;
    localparam logic [3:0] CODE_ADD   = 4'b0010;
    localparam logic [3:0] CODE_NOT   = 4'b0011;
    localparam logic [3:0] CODE_NEG   = 4'b0100;
    localparam logic [3:0] CODE_AND   = 4'b0101;
    localparam logic [3:0] CODE_OR    = 4'b0110;
    localparam logic [3:0] CODE_XOR   = 4'b0111;
    localparam logic [3:0] CODE_SLL   = 4'b1000;
    localparam logic [3:0] CODE_SRL   = 4'b1001;
    localparam logic [3:0] CODE_SHL2A = 4'b1010;
    localparam logic [3:0] CODE_NONE  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_FULL     = 2'b01,
        ST_MUL_WAIT = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct decode to ALU control code, shift select, illegal and multiply flags
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       shamt_sel,
    output logic       illegal,
    output logic       is_mul
);

    always_comb begin
        code      = CODE_NONE;
        shamt_sel = 1'b0;
        illegal   = 1'b0;
        is_mul    = 1'b0;
        case (alu_op)
            ALUOP_ADD: code = CODE_ADD;
            ALUOP_SUB: code = CODE_SUB;
            ALUOP_OR:  code = CODE_OR;
            default: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: code = CODE_ADD;
                    FUNCT_SUB, FUNCT_SUBU: code = CODE_SUB;
                    FUNCT_AND:             code = CODE_AND;
                    FUNCT_OR:              code = CODE_OR;
                    FUNCT_XOR:             code = CODE_XOR;
                    FUNCT_SLL: begin
                        code      = CODE_SLL;
                        shamt_sel = 1'b1;
                    end
                    FUNCT_SRL: begin
                        code      = CODE_SRL;
                        shamt_sel = 1'b1;
                    end
                    FUNCT_MULT, FUNCT_MULTU: begin
                        code   = CODE_MUL;
                        is_mul = 1'b1;
                    end
                    default: begin
                        code    = CODE_NONE;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - one-entry ALU control issue stage with multiply hold; ALU_CTRL_ILLEGAL_TRAP_EN enables the illegal flag
module alu_ctrl_issue
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_control,
    output logic       shamt_sel,
    output logic [4:0] shamt_q,
    output logic       illegal
);

    localparam logic [3:0] MUL_WAIT_INIT = 4'(MUL_LAT - 1);

    issue_state_t state;
    logic [3:0]   cnt;
    logic [3:0]   dec_code;
    logic         dec_shamt_sel;
    logic         dec_illegal;
    logic         dec_is_mul;
    logic         accept;

    alu_ctrl_decode u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .code      (dec_code),
        .shamt_sel (dec_shamt_sel),
        .illegal   (dec_illegal),
        .is_mul    (dec_is_mul)
    );

    assign in_ready  = (state == ST_EMPTY) || ((state == ST_FULL) && out_ready);
    assign out_valid = (state == ST_FULL);
    assign accept    = in_valid && in_ready;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign illegal        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            cnt         <= 4'd0;
            alu_control <= CODE_NONE;
            shamt_sel   <= 1'b0;
            shamt_q     <= 5'd0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else if (accept) begin
            // Accept from EMPTY or a same-cycle reload from FULL behave identically.
            alu_control <= dec_code;
            shamt_sel   <= dec_shamt_sel;
            shamt_q     <= shamt;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q   <= dec_illegal;
`endif
            if (dec_is_mul && (MUL_LAT > 1)) begin
                state <= ST_MUL_WAIT;
                cnt   <= MUL_WAIT_INIT;
            end else begin
                state <= ST_FULL;
            end
        end else begin
            case (state)
                ST_FULL: begin
                    if (out_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= ST_FULL;
                    end
                    cnt <= cnt - 4'd1;
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - randomized self-checking bench for alu_ctrl_issue against a timestamp-based reference model
module tb_alu_ctrl_issue;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [4:0] shamt = 5'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_control;
    logic       shamt_sel;
    logic [4:0] shamt_q;
    logic       illegal;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    alu_ctrl_issue #(.MUL_LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct       (funct),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .shamt_sel   (shamt_sel),
        .shamt_q     (shamt_q),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Reference: {illegal, is_mul, shamt_sel, code[3:0]} straight from the opcode table.
    function automatic logic [6:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {3'b000, 4'b0010};
        if (op == 2'b01) return {3'b000, 4'b0001};
        if (op == 2'b11) return {3'b000, 4'b0110};
        case (f)
            6'b100000, 6'b100001: return {3'b000, 4'b0010};
            6'b100010, 6'b100011: return {3'b000, 4'b0001};
            6'b100100:            return {3'b000, 4'b0101};
            6'b100101:            return {3'b000, 4'b0110};
            6'b100110:            return {3'b000, 4'b0111};
            6'b000000:            return {3'b001, 4'b1000};
            6'b000010:            return {3'b001, 4'b1001};
            6'b011000, 6'b011001: return {3'b010, 4'b0000};
            default:              return {TRAP, 2'b00, 4'b1111};
        endcase
    endfunction

    // Model: the held op plus the cycle number from which it may be presented.
    bit       m_held = 1'b0;
    logic [3:0] m_code = 4'b1111;
    logic     m_sel = 1'b0;
    logic [4:0] m_shamt = 5'd0;
    logic     m_ill = 1'b0;
    int       m_cyc = 0;
    int       m_ready_cyc = 0;

    function automatic bit exp_valid();
        return m_held && (m_cyc >= m_ready_cyc);
    endfunction

    function automatic bit exp_ready(input bit ordy);
        return !m_held || (exp_valid() && ordy);
    endfunction

    always @(posedge clk) begin
        logic [6:0] d;
        if (!reset) begin
            m_held  = 1'b0;
            m_code  = 4'b1111;
            m_sel   = 1'b0;
            m_shamt = 5'd0;
            m_ill   = 1'b0;
        end else if (in_valid && exp_ready(out_ready)) begin
            d           = ref_decode(alu_op, funct);
            m_held      = 1'b1;
            m_code      = d[3:0];
            m_sel       = d[4];
            m_shamt     = shamt;
            m_ill       = d[6];
            m_ready_cyc = m_cyc + (d[5] ? LAT : 1);
        end else if (exp_valid() && out_ready) begin
            m_held = 1'b0;
        end
        m_cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid",   32'(out_valid),   32'(exp_valid()));
            chk("in_ready",    32'(in_ready),    32'(exp_ready(out_ready)));
            chk("alu_control", 32'(alu_control), 32'(m_code));
            chk("shamt_sel",   32'(shamt_sel),   32'(m_sel));
            chk("shamt_q",     32'(shamt_q),     32'(m_shamt));
            chk("illegal",     32'(illegal),     32'(m_ill));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh);
        in_valid = v;
        alu_op   = op;
        funct    = f;
        shamt    = sh;
    endtask

    logic [5:0] funct_pool [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                    6'b100110, 6'b000000, 6'b000010, 6'b011000, 6'b011001, 6'b111111};

    initial begin
        // Reset held low for two cycles.
        step();
        started = 1'b1;
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_code",      32'(alu_control), 32'hF);
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single sub.
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 6'b100010, 5'd0);
        step();
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_code",  32'(alu_control), 32'h1);
        chk("sub_sel",   32'(shamt_sel), 32'd0);

        // Add then sll shamt=5 back to back with the drain of the sub.
        drive(1'b1, 2'b00, 6'b000000, 5'd0);
        step();
        chk("b2b_add_code", 32'(alu_control), 32'h2);
        drive(1'b1, 2'b10, 6'b000000, 5'd5);
        step();
        chk("b2b_sll_valid", 32'(out_valid), 32'd1);
        chk("b2b_sll_code",  32'(alu_control), 32'h8);
        chk("b2b_sll_sel",   32'(shamt_sel), 32'd1);
        chk("b2b_sll_shamt", 32'(shamt_q), 32'd5);
        drive(1'b0, 2'b00, 6'b000000, 5'd0);
        step();

        // Multiply with MUL_LAT=3, then backpressure for five cycles.
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'b011000, 5'd0);
        step();
        drive(1'b1, 2'b10, 6'b100000, 5'd3);
        chk("mul_wait1_ready", 32'(in_ready), 32'd0);
        chk("mul_wait1_valid", 32'(out_valid), 32'd0);
        step();
        chk("mul_wait2_ready", 32'(in_ready), 32'd0);
        step();
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_code",  32'(alu_control), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_code",  32'(alu_control), 32'h0);
        end
        drive(1'b0, 2'b00, 6'b000000, 5'd0);
        out_ready = 1'b1;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Unknown funct.
        drive(1'b1, 2'b10, 6'b111111, 5'd0);
        step();
        drive(1'b0, 2'b00, 6'b000000, 5'd0);
        chk("ill_code", 32'(alu_control), 32'hF);
        chk("ill_flag", 32'(illegal), 32'(TRAP));
        step();

        // Reset in the middle of a multiply wait.
        drive(1'b1, 2'b10, 6'b011001, 5'd9);
        step();
        drive(1'b0, 2'b00, 6'b000000, 5'd0);
        reset = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_code",  32'(alu_control), 32'hF);
        reset = 1'b1;
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 11)];
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), f, 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 99) != 0);
            step();
        end
        reset = 1'b1;
        drive(1'b0, 2'b00, 6'b000000, 5'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
